// File: rtl/spi_lcd_pkg.sv
// Shared types and constants for the 12864 LCD serial path (writer, init and draw controllers).
package spi_lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    DONE
  } spi_state_t;

  localparam int SPI_WORD_W = 10;
  localparam int SPI_CS_BIT = 9;
  localparam int SPI_A0_BIT = 8;

  // CS held high, so the LCD ignores the byte; used to pad the controllers' word streams.
  localparam logic [SPI_WORD_W-1:0] SPI_IDLE_WORD = {2'b11, 8'h2f};

endpackage

// File: rtl/spi_write_module_if.sv
// Start/Data/Done handshake plus LCD pins of the serial writer.
// SPI_WRITE_BUSY_EN adds the Busy_Sig status line.
interface spi_write_module_if;
    import spi_lcd_pkg::*;

    logic                  Start_Sig;
    logic [SPI_WORD_W-1:0] SPI_Data;
    logic                  Done_Sig;
    logic                  LCD_CS;
    logic                  LCD_A0;
    logic                  LCD_SCL;
    logic                  LCD_SDA;
`ifdef SPI_WRITE_BUSY_EN
    logic                  Busy_Sig;
`endif

    modport master (
`ifdef SPI_WRITE_BUSY_EN
        input  Busy_Sig,
`endif
        output Start_Sig,
        output SPI_Data,
        input  Done_Sig,
        input  LCD_CS,
        input  LCD_A0,
        input  LCD_SCL,
        input  LCD_SDA
    );

    modport slave (
`ifdef SPI_WRITE_BUSY_EN
        output Busy_Sig,
`endif
        input  Start_Sig,
        input  SPI_Data,
        output Done_Sig,
        output LCD_CS,
        output LCD_A0,
        output LCD_SCL,
        output LCD_SDA
    );

endinterface

// File: rtl/spi_half_tick.sv
// SCL half-period timer: counts 0..HALF_PERIOD-1, ticks on the last count, clear forces 0.
module spi_half_tick #(
    parameter int HALF_PERIOD = 25
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);
    localparam int                CNT_W = $clog2(HALF_PERIOD + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Wrapping on tick coincides with the state change that tick triggers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_write_module.sv
// 12864 LCD serial writer: latches a CS/A0/byte word and shifts the byte MSB-first on SCL/SDA.
// Define SPI_WRITE_BUSY_EN to drive Busy_Sig on the bus interface.
module spi_write_module
    import spi_lcd_pkg::*;
#(
    parameter int HALF_PERIOD = 25
) (
    input  logic               CLK,
    input  logic               RST,
    spi_write_module_if.slave  bus
);
    spi_state_t state;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       cs_r;
    logic       a0_r;
    logic       scl_r;
    logic       sda_r;
    logic       done_r;
    logic       tick;
    logic       tmr_clr;
`ifdef SPI_WRITE_BUSY_EN
    logic       busy_r;
    assign bus.Busy_Sig = busy_r;
`endif

    assign bus.LCD_CS   = cs_r;
    assign bus.LCD_A0   = a0_r;
    assign bus.LCD_SCL  = scl_r;
    assign bus.LCD_SDA  = sda_r;
    assign bus.Done_Sig = done_r;

    // Timer runs only in the timed states so each one starts from a fresh count.
    assign tmr_clr = (state == IDLE) || (state == DONE);

    spi_half_tick #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_half_tick (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (tmr_clr),
        .tick (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            cs_r    <= 1'b1;
            a0_r    <= 1'b0;
            scl_r   <= 1'b1;
            sda_r   <= 1'b0;
            done_r  <= 1'b0;
`ifdef SPI_WRITE_BUSY_EN
            busy_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start_Sig) begin
                        shift   <= bus.SPI_Data[7:0];
                        cs_r    <= bus.SPI_Data[SPI_CS_BIT];
                        a0_r    <= bus.SPI_Data[SPI_A0_BIT];
                        bit_cnt <= 3'd7;
                        state   <= SETUP;
`ifdef SPI_WRITE_BUSY_EN
                        busy_r  <= 1'b1;
`endif
                    end
                end
                SETUP: begin
                    if (tick) begin
                        scl_r <= 1'b0;
                        sda_r <= shift[7];
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (tick) begin
                        scl_r <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        if (bit_cnt == 3'd0) begin
                            done_r <= 1'b1;
                            cs_r   <= 1'b1;
                            sda_r  <= 1'b0;
                            state  <= DONE;
                        end else begin
                            // SDA takes the next bit on the same edge SCL falls.
                            shift   <= {shift[6:0], 1'b0};
                            bit_cnt <= bit_cnt - 3'd1;
                            scl_r   <= 1'b0;
                            sda_r   <= shift[6];
                            state   <= LOW;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
`ifdef SPI_WRITE_BUSY_EN
                    busy_r <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_write_module.md
# spi_write_module

Serial writer for the 12864 LCD bus: the responder end of the Start_Sig/SPI_Data/Done_Sig handshake driven by the LCD init and draw controllers. Latches one 10-bit command word, drives chip select and A0, and shifts the byte out MSB-first on SCL/SDA. Returns a one-cycle Done_Sig when the byte is complete. Sits between the LCD control FSMs and the LCD pins.

## Interface
- HALF_PERIOD, 25: CLK cycles per SCL half-period; must be ≥1. At 50 MHz CLK, 25 gives SCL = 1 MHz.
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- Start_Sig  in  1  level request; a transfer starts when sampled high in IDLE
- SPI_Data  in  10  [9] CS level for the transfer, [8] A0 (0 = command, 1 = display data), [7:0] byte
- Done_Sig  out  1  one-cycle pulse at end of transfer
- LCD_CS  out  1  chip select, active low
- LCD_A0  out  1  register select
- LCD_SCL  out  1  serial clock, idles high; the LCD samples on the rising edge
- LCD_SDA  out  1  serial data

## Operation
- Reset values: LCD_CS=1, LCD_A0=0, LCD_SCL=1, LCD_SDA=0, Done_Sig=0. State is IDLE and all counters are 0.
- IDLE: if Start_Sig=1:
  - latch SPI_Data into the shift register;
  - drive LCD_CS←SPI_Data[9] and LCD_A0←SPI_Data[8];
  - load bit count 7 and go to SETUP.
- SETUP: lasts HALF_PERIOD cycles with SCL=1. This gives CS/A0 setup time before the first clock. Then go to LOW.
- LOW: on entry, SCL←0 and SDA←shift[7]. Hold for HALF_PERIOD cycles, then go to HIGH.
- HIGH: on entry, SCL←1. Hold for HALF_PERIOD cycles. Then:
  - if bit count = 0, go to DONE;
  - otherwise shift left by 1, decrement bit count, and go to LOW.
- DONE: on entry, Done_Sig←1, LCD_CS←1, SDA←0. Lasts exactly one cycle, then go to IDLE with Done_Sig←0.
- LCD_A0 keeps its last value in IDLE.
- SPI_Data is sampled only in IDLE. Changes during a transfer have no effect.
- Start_Sig is ignored outside IDLE.
- Holding Start_Sig high continuously gives back-to-back transfers, each separated by one IDLE cycle.
- The controller deasserts Start_Sig on the cycle it sees Done_Sig and reasserts it with new data afterwards. In that case the next transfer starts on the first IDLE sample of Start_Sig=1.
- A transfer with SPI_Data[9]=1 still clocks all 8 bits, but with CS high the LCD ignores them. This is how idle words are handled.
- Reset mid-transfer: all outputs return to reset values asynchronously, the transfer is aborted, and no Done_Sig is issued.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Sampling edge E0 (IDLE, Start_Sig=1): CS/A0 are valid in the cycle after E0.
- SDA changes only on SCL falling transitions. SDA is stable for HALF_PERIOD cycles before and HALF_PERIOD cycles after each rising edge of SCL.
- Exactly 8 SCL rising edges occur per transfer.
- Done_Sig is high in cycle 17·HALF_PERIOD+1 after E0 (426 cycles at the default). The earliest next start sample is at edge 17·HALF_PERIOD+2.
- The half-period counter is $clog2(HALF_PERIOD+1) bits wide, counts 0..HALF_PERIOD-1, and clears on every state change.

## Configuration
- SPI_WRITE_BUSY_EN defined: adds output port Busy_Sig (1 bit, reset 0). It is high in every cycle from the cycle after E0 through the DONE cycle inclusive, and low in IDLE.
- SPI_WRITE_BUSY_EN undefined: the port is absent and there is no other behavioural difference.

## Structure
- Shared package spi_lcd_pkg holds:
  - the state typedef (IDLE, SETUP, LOW, HIGH, DONE);
  - SPI_WORD_W=10, SPI_CS_BIT=9, SPI_A0_BIT=8;
  - the idle word {2'b11, 8'h2f}.
- The package is shared with the LCD init and draw controllers.
- One sub-module, spi_half_tick: a HALF_PERIOD counter with a clear input and a terminal-count tick, instantiated once.

## Test plan
- Reset: assert RST for 3 cycles mid-idle → CS=1, SCL=1, SDA=0, A0=0, Done_Sig=0.
- HALF_PERIOD=2, SPI_Data=10'h0AF, Start_Sig pulsed until Done_Sig:
  - CS=0 and A0=0 during the transfer;
  - SDA at the 8 SCL rising edges is 1,0,1,0,1,1,1,1;
  - Done_Sig is high for 1 cycle, 35 cycles after E0;
  - CS=1 afterwards.
- SPI_Data=10'h155: A0=1 throughout, bits 0,1,0,1,0,1,0,1, CS=0.
- Controller-style handshake with words 0AF, 040, 0A6, Start_Sig dropped on Done_Sig and reasserted the next cycle → three complete transfers in order, each with its own Done_Sig pulse.
- SPI_Data changed to 10'h3FF after E0 of a 10'h0C8 transfer → shifted bits are still 1,1,0,0,1,0,0,0.
- RST asserted after the 3rd SCL rising edge → outputs reset immediately and no Done_Sig; a following 10'h0A4 transfer completes with all 8 bits correct.
